// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   state_t      - arbiter FSM encoding
//   NUM_REQ_DEF  - default number of byte requesters
//   TIMEOUT_DEF  - default watchdog limit in clk cycles
//   WD_W         - watchdog counter width
package uart_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int TIMEOUT_DEF = 20000;
  localparam int WD_W        = 15;

  typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;
endpackage

// File: rtl/rr_select.sv
// Round-robin requester picker.
//   valid   - per-requester request vector
//   rr_ptr  - highest-priority requester index (must be < NUM_REQ)
//   grant   - one-hot on the first valid requester at or after rr_ptr
//   index   - binary index of that requester
//   any     - at least one requester is valid
module rr_select #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [2:0]         rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [2:0]         index,
  output logic               any
);
  localparam logic [3:0] N4 = 4'(NUM_REQ);

  logic [3:0] pos;

  // Scan from the far end back toward rr_ptr so the closest valid
  // requester is the last one written and therefore wins.
  always_comb begin
    index = '0;
    any   = 1'b0;
    pos   = '0;
    grant = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      pos = {1'b0, rr_ptr} + 4'(i);
      if (pos >= N4) pos = pos - N4;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (valid[k] && (pos == 4'(k))) begin
          any   = 1'b1;
          index = 3'(k);
        end
      end
    end
    for (int k = 0; k < NUM_REQ; k++) grant[k] = any && (index == 3'(k));
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ byte requesters, round-robin per
// packet: a requester that sends a byte without req_last keeps the grant
// until its last byte. A watchdog aborts a stalled byte or packet.
//   clk, reset               - clock, asynchronous active-high reset
//   req_valid/data/last      - per-requester byte stream
//   req_ready                - one-hot accept strobe
//   tx_start, tx_data        - to uart_tx; tx_data held until the next accept
//   tx_done                  - completion pulse from uart_tx
//   grant_id                 - current or last granted requester
//   busy                     - any state other than IDLE
//   timeout_err              - one-cycle pulse on watchdog expiry
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 timeout_err
);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT);

  state_t              state, state_n;
  logic [2:0]          rr_ptr, next_ptr, xfer_idx, sel_idx;
  logic [NUM_REQ-1:0]  sel_grant, hold_rdy;
  logic                sel_any, lock, xfer, xfer_last, advance, wd_hit;
  logic [7:0]          xfer_data;
  logic [WD_W-1:0]     wd;

  rr_select #(.NUM_REQ(NUM_REQ)) u_sel (
    .valid  (req_valid),
    .rr_ptr (rr_ptr),
    .grant  (sel_grant),
    .index  (sel_idx),
    .any    (sel_any)
  );

  assign next_ptr = (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
  assign wd_hit   = (wd == WD_LIM);
  assign tx_start = (state == START);
  assign busy     = (state != IDLE);

  always_comb begin
    hold_rdy    = '0;
    req_ready   = '0;
    xfer_data   = '0;
    xfer_last   = 1'b0;
    state_n     = state;
    advance     = 1'b0;
    timeout_err = 1'b0;

    for (int k = 0; k < NUM_REQ; k++) hold_rdy[k] = req_valid[k] && (grant_id == 3'(k));

    // Ready is held low during reset so nothing appears accepted.
    if (!reset) begin
      if (state == IDLE)      req_ready = sel_grant;
      else if (state == HOLD) req_ready = hold_rdy;
    end
    xfer     = |req_ready;
    xfer_idx = (state == HOLD) ? grant_id : sel_idx;

    for (int k = 0; k < NUM_REQ; k++) begin
      if (xfer_idx == 3'(k)) begin
        xfer_data = req_data[8*k +: 8];
        xfer_last = req_last[k];
      end
    end

    case (state)
      IDLE:  if (xfer) state_n = START;
      START: state_n = WAIT;
      WAIT: begin
        if (tx_done) begin
          state_n = lock ? HOLD : IDLE;
          advance = !lock;
        end else if (wd_hit) begin
          state_n     = IDLE;
          advance     = 1'b1;
          timeout_err = 1'b1;
        end
      end
      HOLD: begin
        if (xfer) state_n = START;
        else if (wd_hit) begin
          state_n     = IDLE;
          advance     = 1'b1;
          timeout_err = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      tx_data  <= '0;
      lock     <= 1'b0;
      wd       <= '0;
    end else begin
      state <= state_n;
      if (xfer) begin
        tx_data  <= xfer_data;
        grant_id <= xfer_idx;
        lock     <= !xfer_last;
      end
      if (advance) begin
        rr_ptr <= next_ptr;
        lock   <= 1'b0;
      end
      // Watchdog restarts on each entry to WAIT or HOLD.
      if ((state_n == WAIT || state_n == HOLD) && state_n != state) wd <= '0;
      else if (state == WAIT || state == HOLD)                        wd <= wd + 1'b1;
    end
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of byte requesters sharing one uart_tx (range 2..8).
REQ-002 Parameter TIMEOUT, default 20000 clk cycles, SHALL set the watchdog limit for the WAIT and HOLD states.
REQ-003 clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  per-requester byte-available flag.
REQ-006 req_data  input  8*NUM_REQ  per-requester byte; requester k uses bits [8k+7:8k].
REQ-007 req_last  input  NUM_REQ  per-requester end-of-packet flag, qualified by req_valid.
REQ-008 req_ready  output  NUM_REQ  one-hot accept strobe; a byte transfers when req_valid[k] and req_ready[k] are both high.
REQ-009 tx_start  output  1  one-cycle start pulse to uart_tx.
REQ-010 tx_data  output  8  byte to uart_tx, held stable from tx_start until tx_done.
REQ-011 tx_done  input  1  one-cycle completion pulse from uart_tx.
REQ-012 grant_id  output  3  index of the current or last granted requester.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 timeout_err  output  1  one-cycle pulse on watchdog expiry.

Function
REQ-015 States SHALL be IDLE, START, WAIT, HOLD.
REQ-016 In IDLE, req_ready SHALL be combinationally one-hot on the first valid requester at or after rr_ptr, scanning upward with wrap-around, and zero when no req_valid bit is set.
REQ-017 On transfer in IDLE, the arbiter SHALL capture data into tx_data, capture the index into grant_id, capture req_last into a lock flag (lock = !req_last), and enter START.
REQ-018 START SHALL last exactly one cycle with tx_start=1, then enter WAIT; latency from accept to tx_start is 1 cycle.
REQ-019 In WAIT, tx_done SHALL end the byte: lock=0 -> rr_ptr=(grant_id+1) mod NUM_REQ and enter IDLE; lock=1 -> enter HOLD.
REQ-020 In HOLD, only req_ready[grant_id] SHALL be asserted, gated by req_valid[grant_id]; a transfer follows REQ-017 without changing grant_id.
REQ-021 tx_done arriving in IDLE, START, or HOLD SHALL be ignored.
REQ-022 A requester valid in the same cycle tx_done ends a byte SHALL NOT be accepted before the following cycle.
REQ-023 A 15-bit watchdog SHALL clear on entry to WAIT or HOLD and increment each cycle in those states; on reaching TIMEOUT it SHALL pulse timeout_err, clear lock, advance rr_ptr past grant_id, and enter IDLE.
REQ-024 tx_data SHALL change only on a transfer; req_data changes while not granted SHALL be ignored.

Reset
REQ-025 Reset SHALL force IDLE, rr_ptr=0, grant_id=0, tx_data=0x00, lock=0, watchdog=0, and tx_start, busy, timeout_err, req_ready all 0.
REQ-026 Reset asserted mid-byte SHALL abort without a further tx_start; after release, arbitration SHALL restart from requester 0.

Structure
REQ-027 Package uart_pkg SHALL hold the state enumeration and the default NUM_REQ and TIMEOUT constants.
REQ-028 The round-robin selection SHALL be a sub-module rr_select (inputs: valid vector, rr_ptr; outputs: one-hot grant, index, any).

Verification
REQ-029 Requester 0 sends 0xA5 with last=1 -> one tx_start with tx_data=0xA5 one cycle after accept; busy until tx_done; rr_ptr=1 afterwards.
REQ-030 All four requesters hold last=1 continuously (0x11, 0x22, 0x33, 0x44) -> TX order 0x11, 0x22, 0x33, 0x44, 0x11, ...; no requester is skipped or served twice in a round.
REQ-031 Requester 2 sends packet 0x3C, 0xFF, 0x00 (last only on 0x00) while requester 1 stays valid -> the three bytes are transmitted contiguously, then requester 1 is served.
REQ-032 tx_done is held low after tx_start with TIMEOUT=100 -> timeout_err pulses 100 cycles after WAIT entry, state returns to IDLE, and the next requester is granted.
REQ-033 Reset is asserted during WAIT -> all outputs return to their reset values immediately, and a valid requester 3 is granted only after requesters 0..2 are found not valid.
REQ-034 tx_done coincides with requester 1 asserting req_valid -> req_ready[1] rises no earlier than the next cycle, and exactly one tx_start is issued per accepted byte.
